// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared types and constants for the ping/pong frame scheduler
package pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int STAT_W = 16;

    function automatic logic writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    function automatic logic readable(input bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/pingpong_bank.sv
// rtl/pingpong_bank.sv - one frame bank: ownership FSM, storage, write/read pointers, latched length
module pingpong_bank
    import pingpong_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic             rd_en,
    output bank_state_t      state,
    output logic             wr_close,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last
);

    bank_state_t      state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] len_m1;
    logic [WIDTH-1:0] mem [DEPTH];

    // The final slot closes the frame even without wr_last.
    assign wr_close = wr_en && (wr_last || (wr_ptr == PTR_W'(DEPTH - 1)));

    // Gated so that an idle bank (pointer == length) never reports last.
    assign rd_last  = readable(state) && (rd_ptr == len_m1);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (wr_en) begin
                    state_next = wr_close ? FULL : FILLING;
                end
            end
            FILLING: begin
                if (wr_close) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (rd_en) begin
                    state_next = rd_last ? EMPTY : DRAINING;
                end
            end
            DRAINING: begin
                if (rd_en && rd_last) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Length is kept as count-1 so it fits the pointer width at DEPTH entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            len_m1 <= '0;
        end else begin
            if (wr_en) begin
                if (wr_close) begin
                    len_m1 <= wr_ptr;
                    wr_ptr <= '0;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (rd_en) begin
                rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/pingpong_ctrl.sv
// rtl/pingpong_ctrl.sv - double-buffered frame scheduler; PINGPONG_CTRL_STATS_EN adds frame/stall counters
module pingpong_ctrl
    import pingpong_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_last,
    output logic              wr_sel,
    output logic              rd_sel,
    output logic [1:0]        bank_full
`ifdef PINGPONG_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] frame_count,
    output logic [STAT_W-1:0] stall_count
`endif
);

    bank_state_t      bank_st      [2];
    logic [WIDTH-1:0] bank_rd_data [2];
    logic [1:0]       bank_rd_last;
    logic [1:0]       bank_close;
    logic [1:0]       bank_wr_en;
    logic [1:0]       bank_rd_en;
    logic             wr_fire;
    logic             rd_fire;

    // A bank is writable only while EMPTY/FILLING and readable only while FULL/DRAINING,
    // so the two steering paths can never target the same bank in one cycle.
    assign wr_ready = writable(bank_st[wr_sel]);
    assign rd_valid = readable(bank_st[rd_sel]);
    assign rd_data  = bank_rd_data[rd_sel];
    assign rd_last  = bank_rd_last[rd_sel];
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    always_comb begin
        bank_wr_en         = '0;
        bank_rd_en         = '0;
        bank_wr_en[wr_sel] = wr_fire;
        bank_rd_en[rd_sel] = rd_fire;
        for (int i = 0; i < 2; i++) begin
            bank_full[i] = readable(bank_st[i]);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pingpong_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (bank_wr_en[g]),
            .wr_data  (wr_data),
            .wr_last  (wr_last),
            .rd_en    (bank_rd_en[g]),
            .state    (bank_st[g]),
            .wr_close (bank_close[g]),
            .rd_data  (bank_rd_data[g]),
            .rd_last  (bank_rd_last[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (bank_close[wr_sel]) begin
                wr_sel <= ~wr_sel;
            end
            if (rd_fire && rd_last) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

`ifdef PINGPONG_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
            stall_count <= '0;
        end else begin
            if (rd_fire && rd_last && (frame_count != '1)) begin
                frame_count <= frame_count + 1'b1;
            end
            if (wr_valid && !wr_ready && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb/tb_pingpong_ctrl.sv - scoreboard bench for pingpong_ctrl
module tb_pingpong_ctrl;
    import pingpong_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             wr_last;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    logic             wr_sel;
    logic             rd_sel;
    logic [1:0]       bank_full;
`ifdef PINGPONG_CTRL_STATS_EN
    logic [STAT_W-1:0] frame_count;
    logic [STAT_W-1:0] stall_count;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   wr_cnt = 0;

    always #5 clk = ~clk;

    pingpong_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .wr_sel    (wr_sel),
        .rd_sel    (rd_sel),
        .bank_full (bank_full)
`ifdef PINGPONG_CTRL_STATS_EN
        ,
        .frame_count (frame_count),
        .stall_count (stall_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (q.size() == 0) begin
                check("rd_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("rd_data", 64'(rd_data), 64'(mon_e.data));
                check("rd_last", 64'(rd_last), 64'(mon_e.last));
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        q.delete();
        wr_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wr_sel"}, 64'(wr_sel), 64'd0);
        check({tag, "_rd_sel"}, 64'(rd_sel), 64'd0);
        check({tag, "_bank_full"}, 64'(bank_full), 64'd0);
        check({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_rd_last"}, 64'(rd_last), 64'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [WIDTH-1:0] data, input logic last);
        int   n;
        logic exp_last;
        wr_valid = 1'b1;
        wr_data  = data;
        wr_last  = last;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!wr_ready) begin
            check("wr_timeout", 64'd0, 64'd1);
        end else begin
            exp_last = last || (wr_cnt == DEPTH - 1);
            q.push_back({data, exp_last});
            wr_cnt = exp_last ? 0 : wr_cnt + 1;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 64'(q.size()), 64'd0);
        end
        @(posedge clk);
        #1 rd_ready = 1'b0;
    endtask

    initial begin
        do_reset();
        check_idle("reset");

        // 4-entry frame: visible the cycle after the closing write
        for (int i = 0; i < 4; i++) send(32'hA0 + i, i == 3);
        check("t1_rd_valid", 64'(rd_valid), 64'd1);
        check("t1_wr_sel", 64'(wr_sel), 64'd1);
        check("t1_rd_sel", 64'(rd_sel), 64'd0);
        check("t1_bank_full", 64'(bank_full), 64'd1);
        drain();
        check("t1_rd_sel_after", 64'(rd_sel), 64'd1);
        check("t1_rd_valid_after", 64'(rd_valid), 64'd0);
        check("t1_bank_full_after", 64'(bank_full), 64'd0);

        // both banks full, producer blocked for 5 cycles
        do_reset();
        send(32'hB0, 1'b0);
        send(32'hB1, 1'b1);
        send(32'hB2, 1'b0);
        send(32'hB3, 1'b1);
        check("t2_bank_full", 64'(bank_full), 64'd3);
        wr_valid = 1'b1;
        wr_data  = 32'hC0;
        repeat (5) begin
            @(negedge clk);
            check("t2_wr_blocked", 64'(wr_ready), 64'd0);
            @(posedge clk);
        end
        #1 wr_valid = 1'b0;
        drain();
        send(32'hC0, 1'b0);
        send(32'hC1, 1'b1);
        drain();
`ifdef PINGPONG_CTRL_STATS_EN
        check("t2_frame_count", 64'(frame_count), 64'd3);
        check("t2_stall_count", 64'(stall_count), 64'd5);
`endif

        // overlong frame splits at DEPTH, reads run concurrently
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) send(32'h100 + i, i == DEPTH + 1);
        drain();
        check("t3_wr_sel", 64'(wr_sel), 64'd0);
        check("t3_rd_sel", 64'(rd_sel), 64'd0);

        // single-entry frame
        send(32'h55, 1'b1);
        check("t4_bank_full", 64'(bank_full), 64'd1);
        check("t4_rd_valid", 64'(rd_valid), 64'd1);
        check("t4_rd_last", 64'(rd_last), 64'd1);
        drain();
        check("t4_bank_full_after", 64'(bank_full), 64'd0);
        check("t4_wr_sel", 64'(wr_sel), 64'd1);
        check("t4_rd_sel", 64'(rd_sel), 64'd1);

        // reset with one full bank and one partial frame
        do_reset();
        for (int i = 0; i < 4; i++) send(32'hC0 + i, i == 3);
        send(32'hD0, 1'b0);
        send(32'hD1, 1'b0);
        check("t5_bank_full_pre", 64'(bank_full), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        wr_cnt = 0;
        check_idle("t5");
        send(32'hE0, 1'b0);
        send(32'hE1, 1'b1);
        drain();
        check("final_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
